cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the mem / reg_bank / ALU datapath. Each cycle it drives the datapath control pins:
//  - fetches an instruction at pc and decodes it (Opcode[31:29] FonteA[28:27] Dest[26:25] Imediato[24:0]);
//  - drives ALU, memory data port, memory clear and register write-back;
//  - replaces the hand-driven control nets in the integration top.
// PARAMETERS
//  RESET_PC  32'd0  pc value after reset
//  MEM_WAIT  1      cycles mem_en held in MEM state (>=1)
//  ALU_ADD   4'd0   alu_op code for add; ALU_SUB 4'd1, ALU_DIV 4'd2, ALU_MUL 4'd3
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  instr_in   in   32  memory Instruction port (combinational from pc)
//  mem_rdata  in   32  memory DataRead port
//  rf_rdata1  in   32  reg_bank data_src_1
//  rf_rdata2  in   32  reg_bank data_src_2
//  alu_result in   32  ALU rd
//  pc         out  32  memory Read_PC
//  mem_addr   out  32  memory R_W_Addr
//  mem_wdata  out  32  memory DataWrite
//  mem_en     out  1   memory Op2En
//  mem_rw     out  1   memory Op2RW: 1=write, 0=read
//  mem_clear  out  1   memory M_Clear, one-cycle pulse
//  rf_raddr1  out  2   reg_bank src_1 (=FonteA)
//  rf_raddr2  out  2   reg_bank src_2 (=Dest)
//  rf_we      out  1   reg_bank opwrite
//  rf_waddr   out  2   reg_bank reg_write
//  rf_wdata   out  32  reg_bank data
//  alu_a      out  32  ALU rs
//  alu_b      out  32  ALU rt
//  alu_op     out  4   ALU op
//  halted     out  1   high in HALT
//  div0       out  1   sticky divide-by-zero flag
//  state_dbg  out  3   current state encoding
// BEHAVIOUR
//  Reset (async, any state, mid-instruction included):
//  - state=FETCH, pc=RESET_PC, IR=0, wait counter=0; all other outputs 0.
//  - An aborted mem write or write-back does not complete: enables drop in the same cycle.
//  Operand rule: imm = {7'b0, Imediato}, zero-extended.
//  States (state_dbg): FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 CLEAR=5 HALT=6.
//  FETCH:  IR<=instr_in; pc<=pc+1 (2^32-1 wraps to 0); ->DECODE.
//  DECODE: rf_raddr1=FonteA, rf_raddr2=Dest.
//    - 101 -> HALT; 100 -> CLEAR.
//    - 010 with imm==0 -> div0<=1, ->FETCH (no write-back).
//    - otherwise ->EXEC.
//  EXEC:   alu_a=rf_rdata1, alu_b=imm; result reg <= alu_result.
//    - alu_op: 000 ADD, 001 SUB, 010 DIV, 011 MUL; 110/111 ADD (address).
//    - ALU ops ->WB; 110/111 ->MEM.
//  MEM:    mem_addr=result; mem_en=1 for MEM_WAIT cycles (down-counter).
//    - 111: mem_rw=1, mem_wdata=rf_rdata2 (R[Dest]); last cycle ->FETCH.
//    - 110: mem_rw=0; last cycle latch mem_rdata into result ->WB.
//  WB:     rf_we=1, rf_waddr=Dest, rf_wdata=result; 1 cycle; ->FETCH.
//  CLEAR:  mem_clear=1 one cycle; ->FETCH.
//  HALT:   halted=1; all enables 0; pc frozen; exit only via rst.
//  Latency (MEM_WAIT=1): ALU op 4 cycles, read 5, write 4, clear 3, halt 2 to halted.
//  Control outputs (mem_en, rf_we, mem_clear) are registered, never combinational from instr_in.
//  div0: sticky until rst; does not stop execution.
// CONFIGURATION
//  SEQ_STEP_EN defined:
//  - adds input `step` (1 bit).
//  - FETCH is held (no IR load, no pc increment) until step==1 is sampled on a clk edge.
//  - one instruction per step pulse; step held high runs freely.
//  SEQ_STEP_EN undefined: no step port; FETCH always advances.
// TESTING
//  1 rst pulse mid-WB (rf_we=1) -> rf_we, pc, and state_dbg read 0 immediately, before the next clk edge.
//  2 R1=5 (rf_rdata1=5), instr {000,01,10,25'd7}:
//    - alu_op=0, alu_b=7, alu_result=12;
//    - 4th cycle rf_we=1, rf_waddr=2, rf_wdata=12; pc 0->1.
//  3 instr {111,00,01,25'd4}, R0=8, R1=0xAB:
//    - MEM: mem_en=1, mem_rw=1, mem_addr=12, mem_wdata=0xAB;
//    - next {110,00,11,25'd4}: rf_wdata=mem_rdata=0xAB to reg 3.
//  4 instr {010,00,01,25'd0} -> div0=1, no rf_we; next instr executes normally.
//  5 instr {100,...} -> mem_clear high exactly 1 cycle.
//    - then {101,...} -> halted=1, pc frozen for 20 cycles.
//  6 RESET_PC=32'hFFFF_FFFF, one add -> pc wraps to 0.
//    - SEQ_STEP_EN: no step -> state_dbg stays 0 for 10 cycles; one step pulse -> exactly one instruction.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - datapath control/data bus between the sequencer and mem/reg_bank/ALU
interface cpu_sequencer_if;
   // memory ports
   logic [31:0] pc;
   logic [31:0] instr_in;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_en;
   logic        mem_rw;
   logic        mem_clear;
   // register bank ports
   logic [1:0]  rf_raddr1;
   logic [1:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        rf_we;
   logic [1:0]  rf_waddr;
   logic [31:0] rf_wdata;
   // ALU ports
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;

   modport master (
      output pc, mem_addr, mem_wdata, mem_en, mem_rw, mem_clear,
      output rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
      output alu_a, alu_b, alu_op,
      input  instr_in, mem_rdata, rf_rdata1, rf_rdata2, alu_result
   );

   modport slave (
      input  pc, mem_addr, mem_wdata, mem_en, mem_rw, mem_clear,
      input  rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
      input  alu_a, alu_b, alu_op,
      output instr_in, mem_rdata, rf_rdata1, rf_rdata2, alu_result
   );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control FSM for the mem/reg_bank/ALU datapath (optional SEQ_STEP_EN single-step)
module cpu_sequencer #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          MEM_WAIT = 1,
   parameter logic [3:0]  ALU_ADD  = 4'd0,
   parameter logic [3:0]  ALU_SUB  = 4'd1,
   parameter logic [3:0]  ALU_DIV  = 4'd2,
   parameter logic [3:0]  ALU_MUL  = 4'd3
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SEQ_STEP_EN
   input  logic              step,
`endif
   cpu_sequencer_if.master   bus,
   output logic              halted,
   output logic              div0,
   output logic [2:0]        state_dbg
);

   localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_CLEAR  = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t          state;
   logic [31:0]     ir;
   logic [CW-1:0]   wait_cnt;
   logic            fetch_go;

   // instruction fields; register addresses come straight from IR so they are stable from DECODE on
   logic [2:0]  opcode;
   logic [1:0]  dest;
   logic [31:0] imm;
   assign opcode        = ir[31:29];
   assign dest          = ir[26:25];
   assign imm           = {7'b0, ir[24:0]};
   assign bus.rf_raddr1 = ir[28:27];
   assign bus.rf_raddr2 = ir[26:25];
   assign state_dbg     = state;

`ifdef SEQ_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   // sequencer FSM; every datapath control pin is a register set on entry to the state that uses it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FETCH;
         ir            <= '0;
         wait_cnt      <= '0;
         bus.pc        <= RESET_PC;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_rw    <= 1'b0;
         bus.mem_clear <= 1'b0;
         bus.rf_we     <= 1'b0;
         bus.rf_waddr  <= '0;
         bus.rf_wdata  <= '0;
         bus.alu_a     <= '0;
         bus.alu_b     <= '0;
         bus.alu_op    <= '0;
         halted        <= 1'b0;
         div0          <= 1'b0;
      end else begin
         // strobes fall back to idle unless the next state re-asserts them
         bus.mem_en    <= 1'b0;
         bus.mem_rw    <= 1'b0;
         bus.mem_clear <= 1'b0;
         bus.rf_we     <= 1'b0;
         case (state)
            S_FETCH: begin
               if (fetch_go) begin
                  ir     <= bus.instr_in;
                  bus.pc <= bus.pc + 32'd1;
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (opcode == 3'b101) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (opcode == 3'b100) begin
                  bus.mem_clear <= 1'b1;
                  state         <= S_CLEAR;
               end else if (opcode == 3'b010 && imm == 32'd0) begin
                  div0  <= 1'b1;
                  state <= S_FETCH;
               end else begin
                  bus.alu_a <= bus.rf_rdata1;
                  bus.alu_b <= imm;
                  case (opcode)
                     3'b001:  bus.alu_op <= ALU_SUB;
                     3'b010:  bus.alu_op <= ALU_DIV;
                     3'b011:  bus.alu_op <= ALU_MUL;
                     default: bus.alu_op <= ALU_ADD;
                  endcase
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (opcode[2:1] == 2'b11) begin
                  bus.mem_addr  <= bus.alu_result;
                  bus.mem_wdata <= bus.rf_rdata2;
                  bus.mem_en    <= 1'b1;
                  bus.mem_rw    <= opcode[0];
                  wait_cnt      <= CW'(MEM_WAIT - 1);
                  state         <= S_MEM;
               end else begin
                  bus.rf_we    <= 1'b1;
                  bus.rf_waddr <= dest;
                  bus.rf_wdata <= bus.alu_result;
                  state        <= S_WB;
               end
            end
            S_MEM: begin
               if (wait_cnt == '0) begin
                  if (opcode[0]) begin
                     state <= S_FETCH;
                  end else begin
                     bus.rf_we    <= 1'b1;
                     bus.rf_waddr <= dest;
                     bus.rf_wdata <= bus.mem_rdata;
                     state        <= S_WB;
                  end
               end else begin
                  wait_cnt   <= wait_cnt - 1'b1;
                  bus.mem_en <= 1'b1;
                  bus.mem_rw <= opcode[0];
               end
            end
            S_WB:    state <= S_FETCH;
            S_CLEAR: state <= S_FETCH;
            S_HALT:  halted <= 1'b1;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer with a behavioural mem/reg_bank/ALU datapath
module tb_cpu_sequencer;

   typedef struct packed {
      logic        kind;   // 0 = register write-back, 1 = memory write
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   localparam logic [31:0] I_HALT = 32'hA000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic step = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   ev_t  sb[$];

   logic [31:0] imem [0:15];
   logic [31:0] dmem [0:15];
   logic [31:0] rf   [0:3];
   logic [31:0] rf_seed [0:3];
   logic [31:0] alu_res;

   logic       halted, div0, w_halted, w_div0;
   logic [2:0] state_dbg, w_state;

   cpu_sequencer_if bus ();
   cpu_sequencer_if bus2 ();

   always #5 clk = ~clk;

   cpu_sequencer u_dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SEQ_STEP_EN
      .step      (step),
`endif
      .bus       (bus),
      .halted    (halted),
      .div0      (div0),
      .state_dbg (state_dbg)
   );

   cpu_sequencer #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
      .clk       (clk),
      .rst       (rst),
`ifdef SEQ_STEP_EN
      .step      (1'b1),
`endif
      .bus       (bus2),
      .halted    (w_halted),
      .div0      (w_div0),
      .state_dbg (w_state)
   );

   // datapath model for the main instance
   assign bus.instr_in   = imem[bus.pc[3:0]];
   assign bus.rf_rdata1  = rf[bus.rf_raddr1];
   assign bus.rf_rdata2  = rf[bus.rf_raddr2];
   assign bus.mem_rdata  = dmem[bus.mem_addr[3:0]];
   assign bus.alu_result = alu_res;

   always_comb begin
      alu_res = 32'd0;
      case (bus.alu_op)
         4'd0: alu_res = bus.alu_a + bus.alu_b;
         4'd1: alu_res = bus.alu_a - bus.alu_b;
         4'd2: alu_res = (bus.alu_b == 32'd0) ? 32'd0 : bus.alu_a / bus.alu_b;
         4'd3: alu_res = bus.alu_a * bus.alu_b;
         default: alu_res = 32'd0;
      endcase
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rf[i] <= rf_seed[i];
         for (int i = 0; i < 16; i++) dmem[i] <= 32'd0;
      end else begin
         if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
         if (bus.mem_en && bus.mem_rw) dmem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      end
   end

   // second instance only runs a free adder loop to exercise pc wrap
   assign bus2.instr_in   = 32'h0000_0001;
   assign bus2.rf_rdata1  = 32'd0;
   assign bus2.rf_rdata2  = 32'd0;
   assign bus2.mem_rdata  = 32'd0;
   assign bus2.alu_result = bus2.alu_a + bus2.alu_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic sb_check(input ev_t got);
      ev_t exp;
      n_cmp++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL sb_unexpected got=%h exp=none", got);
      end
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         n_cmp++;
         assert (got === exp) else begin
            n_err++;
            $error("FAIL sb_event got=%h exp=%h", got, exp);
         end
      end
   endtask

   // scoreboard monitor: every write-back and memory write must match the next expected event
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rf_we) sb_check({1'b0, {30'b0, bus.rf_waddr}, bus.rf_wdata});
         if (bus.mem_en && bus.mem_rw) sb_check({1'b1, bus.mem_addr, bus.mem_wdata});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] s0, s1, s2, s3);
      rf_seed[0] = s0; rf_seed[1] = s1; rf_seed[2] = s2; rf_seed[3] = s3;
      for (int i = 0; i < 16; i++) imem[i] = I_HALT;
   endtask

   task automatic restart();
      @(posedge clk);
      #1 rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic run_to_halt(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (halted) break;
         cyc();
      end
      chk("halt_reached", 32'(halted), 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   int cnt, ncl;
   logic [31:0] pc_hold;

   initial begin
      load(32'd0, 32'd5, 32'd0, 32'd0);
      imem[0] = {3'b000, 2'b01, 2'b10, 25'd7};
      // reset state
      cyc(); cyc();
      chk("rst_state", 32'(state_dbg), 32'd0);
      chk("rst_pc", bus.pc, 32'd0);
      chk("rst_ctrl", {29'd0, bus.rf_we, bus.mem_en, bus.mem_clear}, 32'd0);
      chk("rst_flags", {30'd0, halted, div0}, 32'd0);
      chk("rst_wrap_pc", bus2.pc, 32'hFFFF_FFFF);

      // ALU add R1(5)+7 -> R2
      sb.push_back({1'b0, 32'd2, 32'd12});
      rst = 1'b0;
      cyc();
      chk("wrap_pc", bus2.pc, 32'd0);
      chk("add_pc1", bus.pc, 32'd1);
      chk("add_st_dec", 32'(state_dbg), 32'd1);
      cyc();
      chk("add_st_exec", 32'(state_dbg), 32'd2);
      chk("add_alu_a", bus.alu_a, 32'd5);
      chk("add_alu_b", bus.alu_b, 32'd7);
      chk("add_alu_op", 32'(bus.alu_op), 32'd0);
      cyc();
      chk("add_st_wb", 32'(state_dbg), 32'd4);
      chk("add_we", 32'(bus.rf_we), 32'd1);
      chk("add_waddr", 32'(bus.rf_waddr), 32'd2);
      chk("add_wdata", bus.rf_wdata, 32'd12);
      cyc();
      chk("add_st_fetch", 32'(state_dbg), 32'd0);
      chk("add_we_drop", 32'(bus.rf_we), 32'd0);
      run_to_halt(20);
      chk("add_halt_pc", bus.pc, 32'd2);

      // memory write then read back
      load(32'd8, 32'hAB, 32'd0, 32'd0);
      imem[0] = {3'b111, 2'b00, 2'b01, 25'd4};
      imem[1] = {3'b110, 2'b00, 2'b11, 25'd4};
      sb.push_back({1'b1, 32'd12, 32'hAB});
      sb.push_back({1'b0, 32'd3, 32'hAB});
      restart();
      cyc(); cyc(); cyc();
      chk("st_state", 32'(state_dbg), 32'd3);
      chk("st_en_rw", {30'd0, bus.mem_en, bus.mem_rw}, 32'd3);
      chk("st_addr", bus.mem_addr, 32'd12);
      chk("st_wdata", bus.mem_wdata, 32'hAB);
      cyc();
      chk("st_done", {28'd0, state_dbg, bus.mem_en}, 32'd0);
      cyc(); cyc(); cyc();
      chk("ld_en_rw", {28'd0, state_dbg, bus.mem_en}, {28'd0, 3'd3, 1'b1});
      chk("ld_rw", 32'(bus.mem_rw), 32'd0);
      cyc();
      chk("ld_wb", {28'd0, state_dbg, bus.rf_we}, {28'd0, 3'd4, 1'b1});
      run_to_halt(20);

      // divide by zero, then normal ALU ops
      load(32'd0, 32'd6, 32'd0, 32'd0);
      imem[0] = {3'b010, 2'b00, 2'b01, 25'd0};
      imem[1] = {3'b011, 2'b01, 2'b10, 25'd3};
      imem[2] = {3'b001, 2'b01, 2'b00, 25'd2};
      imem[3] = {3'b010, 2'b01, 2'b11, 25'd3};
      sb.push_back({1'b0, 32'd2, 32'd18});
      sb.push_back({1'b0, 32'd0, 32'd4});
      sb.push_back({1'b0, 32'd3, 32'd2});
      restart();
      chk("div0_clear", 32'(div0), 32'd0);
      cyc(); cyc();
      chk("div0_set", {28'd0, state_dbg, div0}, {28'd0, 3'd0, 1'b1});
      chk("div0_pc", bus.pc, 32'd1);
      run_to_halt(40);
      chk("div0_sticky", 32'(div0), 32'd1);

      // async reset in the middle of write-back aborts the write
      load(32'd0, 32'd5, 32'd0, 32'd0);
      imem[0] = {3'b000, 2'b01, 2'b10, 25'd7};
      restart();
      cnt = 0;
      while (state_dbg != 3'd4 && cnt < 10) begin
         cyc();
         cnt++;
      end
      chk("mid_wb_found", {28'd0, state_dbg, bus.rf_we}, {28'd0, 3'd4, 1'b1});
      rst = 1'b1;
      #1;
      chk("mid_wb_we", 32'(bus.rf_we), 32'd0);
      chk("mid_wb_pc", bus.pc, 32'd0);
      chk("mid_wb_state", 32'(state_dbg), 32'd0);
      cyc();
      rst = 1'b0;

      // memory clear pulse then halt, pc frozen
      load(32'd0, 32'd0, 32'd0, 32'd0);
      imem[0] = {3'b100, 29'd0};
      restart();
      cnt = 0;
      ncl = 0;
      while (!halted && cnt < 20) begin
         cyc();
         cnt++;
         if (bus.mem_clear) ncl++;
      end
      chk("clr_pulses", 32'(ncl), 32'd1);
      chk("clr_halt_lat", 32'(cnt), 32'd5);
      pc_hold = bus.pc;
      repeat (20) cyc();
      chk("halt_pc_frozen", bus.pc, pc_hold);
      chk("halt_pc_val", bus.pc, 32'd2);
      chk("halt_state", {28'd0, state_dbg, halted}, {28'd0, 3'd6, 1'b1});

`ifdef SEQ_STEP_EN
      // single step: fetch holds until a step pulse, then exactly one instruction runs
      load(32'd0, 32'd5, 32'd0, 32'd0);
      imem[0] = {3'b000, 2'b01, 2'b10, 25'd7};
      step = 1'b0;
      restart();
      repeat (10) cyc();
      chk("step_hold_state", 32'(state_dbg), 32'd0);
      chk("step_hold_pc", bus.pc, 32'd0);
      sb.push_back({1'b0, 32'd2, 32'd12});
      step = 1'b1;
      cyc();
      step = 1'b0;
      repeat (10) cyc();
      chk("step_one_pc", bus.pc, 32'd1);
      chk("step_one_state", 32'(state_dbg), 32'd0);
      chk("step_sb", 32'(sb.size()), 32'd0);
      step = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
